// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide unit owning HI/LO.
// Shift-add multiply and restoring divide run on magnitudes for 32 cycles,
// followed by one sign-fix cycle that writes HI/LO (33-cycle latency).
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] in_s1,
    input  logic [31:0] in_s2,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic [63:0] acc_reg;      // mul: {partial product, multiplier}; div: {rem, quot}
    logic [31:0] opnd_reg;     // multiplicand magnitude or divisor magnitude
    logic        is_div_reg;
    logic        neg_q_reg;    // negate product / quotient
    logic        neg_r_reg;    // negate remainder (dividend was negative)
    logic        dz_reg;
    logic [31:0] hi_reg, lo_reg;
    logic        done_reg, dbz_reg;

    logic        accept, muldiv_go;
    logic        s1_neg, s2_neg;
    logic [31:0] abs_s1, abs_s2;
    logic [32:0] mul_sum;
    logic [32:0] div_top;
    logic [33:0] div_diff;
    logic [63:0] acc_step;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    assign accept    = start && (state_reg == IDLE) && !(op[2] && op[1]);
    assign muldiv_go = accept && !op[2];
    assign s1_neg    = op[0] && in_s1[31];
    assign s2_neg    = op[0] && in_s2[31];
    assign abs_s1    = s1_neg ? (32'd0 - in_s1) : in_s1;
    assign abs_s2    = s2_neg ? (32'd0 - in_s2) : in_s2;

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: 32 RUN cycles then a single FIX cycle.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (muldiv_go) state_next = RUN;
            RUN:     if (count_reg == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        div_top  = acc_reg[63:31];
        div_diff = {1'b0, div_top} - {2'b00, opnd_reg};
        if (is_div_reg) begin
            if (div_diff[33]) acc_step = {div_top[31:0], acc_reg[30:0], 1'b0};
            else              acc_step = {div_diff[31:0], acc_reg[30:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_reg[31:1]};
        end
    end

    // Sign correction of the magnitude result. For divide-by-zero the
    // remainder ends up equal to |dividend|, so restoring the dividend sign
    // reproduces the original in_s1 for HI; only LO needs forcing.
    always_comb begin
        prod_fix = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
        quot_fix = neg_q_reg ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
        rem_fix  = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
    end

    // Datapath, HI/LO and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= 5'd0;
            acc_reg    <= 64'd0;
            opnd_reg   <= 32'd0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (accept && op[2]) begin
                        if (op[0]) lo_reg <= in_s1;
                        else       hi_reg <= in_s1;
                    end else if (muldiv_go) begin
                        count_reg  <= 5'd0;
                        is_div_reg <= op[1];
                        neg_q_reg  <= s1_neg ^ s2_neg;
                        neg_r_reg  <= s1_neg;
                        dz_reg     <= op[1] && (in_s2 == 32'd0);
                        if (op[1]) begin
                            acc_reg  <= {32'd0, abs_s1};
                            opnd_reg <= abs_s2;
                        end else begin
                            acc_reg  <= {32'd0, abs_s2};
                            opnd_reg <= abs_s1;
                        end
                    end
                end
                RUN: begin
                    acc_reg   <= acc_step;
                    count_reg <= count_reg + 5'd1;
                end
                FIX: begin
                    done_reg <= 1'b1;
                    dbz_reg  <= dz_reg;
                    if (!is_div_reg) begin
                        hi_reg <= prod_fix[63:32];
                        lo_reg <= prod_fix[31:0];
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= dz_reg ? 32'hFFFF_FFFF : quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that owns the architectural HI/LO registers and sits beside the ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode, computes over a fixed 33-cycle latency, and drives HI/LO so the ALU's MFHI/MFLO path reads registered, stable values. Upstream decode stalls on `busy` before issuing MFHI/MFLO or a new mul/div.

## Interface
- No parameters; datapath fixed at 32 bits, result 64 bits.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request valid this cycle.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x ignored.
- in_s1  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- in_s2  in  32  rt operand: multiplier or divisor.
- busy  out  1  iteration in progress; start ignored while high.
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div.
- div_by_zero  out  1  one-cycle pulse with done when a DIV/DIVU had in_s2 == 0.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- Accept = start && !busy && op is valid. Start while busy is dropped, not queued.
- MTHI/MTLO: hi (or lo) <= in_s1 on the accept edge; busy stays 0; no done pulse.
- Mul/div accept edge: latch signed flag, op class, |in_s1|, |in_s2| (absolute values for signed ops, raw for unsigned), result sign bits, count <= 0, state IDLE -> RUN.
- States: IDLE, RUN, FIX.
  - RUN, multiply: shift-add; each cycle conditionally adds the multiplicand into the 64-bit accumulator on the multiplier LSB, then shifts. 32 cycles.
  - RUN, divide: restoring; each cycle shifts {rem, quot} left by 1, trial-subtracts the divisor from the 33-bit remainder, keeps the subtraction if non-negative, and sets the quotient bit. 32 cycles.
  - RUN -> FIX when count == 31; count wraps to 0.
  - FIX: applies sign correction and writes hi/lo. Next state is IDLE.
- Sign rules:
  - Signed product is negated (64-bit two's complement) when operand signs differ.
  - Signed quotient is negated when signs differ; the remainder takes the sign of the dividend.
- Results: mul writes {hi, lo} = product. Div writes lo = quotient, hi = remainder.
- Divide by zero, signed or unsigned: lo = 32'hFFFFFFFF, hi = in_s1 as latched (original signed value). div_by_zero pulses with done.
- Signed overflow -2^31 / -1: lo = 32'h80000000, hi = 0. div_by_zero stays 0.
- hi/lo hold their old values for the whole operation. They change only on the FIX edge or an MTHI/MTLO accept.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, state IDLE, count = 0.
- rst asserted mid-operation aborts the operation: nothing is written to HI/LO except the reset clear, and no done pulse is produced.
- Accept at edge E0:
  - busy = 1 after E0.
  - RUN on edges E1..E32; FIX on edge E33.
  - After E33: busy = 0, done = 1 for exactly one cycle, new hi/lo valid.
- Latency: 33 cycles from accept to valid result. busy is high for exactly 33 cycles.
- Back-to-back: a start in the done cycle is accepted, since busy = 0. Minimum issue interval is 34 cycles.
- MTHI/MTLO issued in the done cycle overwrites the just-written register on that edge.
- rst and start in the same cycle: rst wins.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done 33 cycles after accept; hi = 0xFFFFFFFE, lo = 0x00000001; busy high for exactly 33 cycles.
- MULT -3 × 5 (0xFFFFFFFD, 0x00000005) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> hi = 0x40000000, lo = 0.
- DIVU 100 / 7 -> lo = 0x0000000E, hi = 0x00000002. DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU 0x1234 / 0 -> lo = 0xFFFFFFFF, hi = 0x00001234, div_by_zero pulses with done.
- MTHI 0xAAAA5555 while idle -> hi updates next edge, busy stays 0, no done. MTLO and MULT issued while busy -> ignored; hi/lo and the in-flight result are unaffected.
- Assert rst at cycle 10 of a DIV -> next cycle busy = 0, hi = lo = 0, no done. A new MULTU issued afterwards completes with the correct result.
